ds1302_rtc_responder: RTL and testbench

//  Responder (slave) end of the DS1302 3-wire interface: emulates the DS1302 clock registers so the
//  ds1302 master logic and the BCD display path can run on-board or in simulation without the chip.

---
 rtl/ds1302_rtc_responder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ds1302_rtc_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ds1302_rtc_responder.sv
// DS1302 responder: emulates the clock registers of a DS1302 behind its
// 3-wire CE/SCLK/IO interface and keeps time from a prescaled 1 Hz tick.
// All master-side pins are asynchronous and are resampled on sclk.
module ds1302_rtc_responder #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        ds1302_ce,
  input  logic        ds1302_sclk,
  inout  wire         ds1302_io,
  output logic [63:0] bcd_time,
  output logic        tick_pulse,
  output logic        xfer_done,
  output logic [7:0]  xfer_cmd
);

  localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  state_t state, state_next;

  // synchronisers and SCLK edge detection
  logic [1:0] ce_sync, sck_sync, io_sync;
  logic       sck_prev;
  logic       ce_s, io_s, sck_rise, sck_fall;

  // transfer datapath
  logic [6:0]  bit_cnt;
  logic [6:0]  cmd_sr;
  logic [7:0]  cmd_reg;
  logic        burst_reg;
  logic [62:0] wr_sr;
  logic [63:0] rd_buf;
  logic        io_out, io_oe;

  // clock registers: 0 sec, 1 min, 2 hour, 3 date, 4 month, 5 day, 6 year, 7 wp
  logic [7:0]    rtc_reg [0:7];
  logic [PW-1:0] presc;

  // strobes from the FSM and decoded write/tick controls
  logic [7:0]  cmd_full;
  logic [63:0] wr_full;
  logic [6:0]  last_idx;
  logic        cmd_end, wr_shift, wr_commit, rd_drive, rd_last, rd_release;
  logic [63:0] snap;
  logic [7:0]  wr_en;
  logic [63:0] wr_bytes;
  logic        tick, tick_apply;
  logic [8:0]  sec_inc, min_inc, hour_inc;

  assign ce_s     = ce_sync[1];
  assign io_s     = io_sync[1];
  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign sck_fall = ~sck_sync[1] & sck_prev;
  assign cmd_full = {io_s, cmd_sr};
  assign wr_full  = {io_s, wr_sr};
  assign last_idx = burst_reg ? 7'd63 : 7'd7;

  assign ds1302_io = io_oe ? io_out : 1'bz;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_time
      assign bcd_time[gi*8 +: 8] = rtc_reg[gi];
    end
  endgenerate

  // BCD increment that wraps to zero at or beyond max_v; units above 9 carry into tens
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v >= max_v)
      return 9'h100;
    else if (v[3:0] >= 4'd9)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // two-stage resampling of the master pins
  always_ff @(posedge sclk) begin
    if (rst) begin
      ce_sync  <= '0;
      sck_sync <= '0;
      io_sync  <= '0;
      sck_prev <= 1'b0;
    end else begin
      ce_sync  <= {ce_sync[0], ds1302_ce};
      sck_sync <= {sck_sync[0], ds1302_sclk};
      io_sync  <= {io_sync[0], ds1302_io};
      sck_prev <= sck_sync[1];
    end
  end

  // FSM state register
  always_ff @(posedge sclk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state and per-cycle transfer strobes; CE low overrides everything
  always_comb begin
    state_next = state;
    cmd_end    = 1'b0;
    wr_shift   = 1'b0;
    wr_commit  = 1'b0;
    rd_drive   = 1'b0;
    rd_last    = 1'b0;
    rd_release = 1'b0;
    case (state)
      ST_IDLE: if (ce_s) state_next = ST_CMD;
      ST_CMD: begin
        if (sck_rise && bit_cnt == 7'd7) begin
          cmd_end = 1'b1;
          if (!cmd_full[7])     state_next = ST_IGNORE;
          else if (cmd_full[0]) state_next = ST_RDATA;
          else if (cmd_full[6]) state_next = ST_IGNORE;
          else                  state_next = ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (sck_rise && bit_cnt <= last_idx) begin
          wr_shift  = 1'b1;
          wr_commit = (bit_cnt == last_idx);
        end
      end
      ST_RDATA: begin
        if (sck_fall) begin
          if (bit_cnt <= last_idx) begin
            rd_drive = 1'b1;
            rd_last  = (bit_cnt == last_idx);
          end else begin
            rd_release = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (!ce_s) begin
      state_next = ST_IDLE;
      cmd_end    = 1'b0;
      wr_shift   = 1'b0;
      wr_commit  = 1'b0;
      rd_drive   = 1'b0;
      rd_last    = 1'b0;
      rd_release = 1'b0;
    end
  end

  // read snapshot taken at the end of the command byte
  always_comb begin
    snap = '0;
    if (!cmd_full[6]) begin
      if (cmd_full[5:1] == 5'd31)
        snap = bcd_time;
      else if (cmd_full[5:4] == 2'b00)
        snap = {56'd0, rtc_reg[cmd_full[3:1]]};
    end
  end

  // write enables per register; write protect blocks 0-6 but never wp itself
  always_comb begin
    wr_en    = '0;
    wr_bytes = burst_reg ? wr_full : {8{wr_full[63:56]}};
    if (wr_commit) begin
      if (burst_reg) begin
        wr_en[7] = 1'b1;
        if (!rtc_reg[7][7]) wr_en[6:0] = '1;
      end else if (!cmd_reg[6] && cmd_reg[5:4] == 2'b00) begin
        if (cmd_reg[3:1] == 3'd7 || !rtc_reg[7][7]) wr_en[cmd_reg[3:1]] = 1'b1;
      end
    end
  end

  // tick generation; a coinciding commit swallows the tick
  always_comb begin
    tick       = !rtc_reg[0][7] && (presc == PRESC_MAX);
    tick_apply = tick && !wr_commit;
    sec_inc    = bcd_inc(rtc_reg[0], 8'h59);
    min_inc    = bcd_inc(rtc_reg[1], 8'h59);
    hour_inc   = bcd_inc(rtc_reg[2], 8'h23);
  end

  // serial shift, snapshot, read drive and transfer-complete reporting
  always_ff @(posedge sclk) begin
    if (rst) begin
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      cmd_reg   <= '0;
      burst_reg <= 1'b0;
      wr_sr     <= '0;
      rd_buf    <= '0;
      io_out    <= 1'b0;
      io_oe     <= 1'b0;
      xfer_done <= 1'b0;
      xfer_cmd  <= '0;
    end else begin
      xfer_done <= 1'b0;
      if (!ce_s) begin
        bit_cnt <= '0;
        io_oe   <= 1'b0;
      end else begin
        if (cmd_end) begin
          bit_cnt   <= '0;
          cmd_sr    <= cmd_full[7:1];
          cmd_reg   <= cmd_full;
          burst_reg <= !cmd_full[6] && (cmd_full[5:1] == 5'd31);
          rd_buf    <= snap;
        end else if (state == ST_CMD && sck_rise) begin
          cmd_sr  <= cmd_full[7:1];
          bit_cnt <= bit_cnt + 7'd1;
        end
        if (wr_shift) begin
          wr_sr   <= wr_full[63:1];
          bit_cnt <= bit_cnt + 7'd1;
        end
        if (rd_drive) begin
          io_out  <= rd_buf[bit_cnt[5:0]];
          io_oe   <= 1'b1;
          bit_cnt <= bit_cnt + 7'd1;
        end
        if (rd_release) io_oe <= 1'b0;
        if (wr_commit || rd_last) begin
          xfer_done <= 1'b1;
          xfer_cmd  <= cmd_reg;
        end
      end
    end
  end

  // clock registers, prescaler and seconds roll-over chain
  always_ff @(posedge sclk) begin
    if (rst) begin
      rtc_reg[0] <= 8'h80;
      rtc_reg[1] <= 8'h00;
      rtc_reg[2] <= 8'h00;
      rtc_reg[3] <= 8'h01;
      rtc_reg[4] <= 8'h01;
      rtc_reg[5] <= 8'h01;
      rtc_reg[6] <= 8'h00;
      rtc_reg[7] <= 8'h80;
      presc      <= '0;
      tick_pulse <= 1'b0;
    end else begin
      tick_pulse <= tick_apply;
      for (int i = 0; i < 8; i++) begin
        if (wr_en[i]) begin
          if (i == 2) rtc_reg[i] <= {1'b0, wr_bytes[i*8 +: 7]};
          else        rtc_reg[i] <= wr_bytes[i*8 +: 8];
        end
      end
      if (tick_apply) begin
        rtc_reg[0] <= sec_inc[7:0];
        if (sec_inc[8]) begin
          rtc_reg[1] <= min_inc[7:0];
          // hour wraps 23 -> 00 and stops there; date is not advanced
          if (min_inc[8]) rtc_reg[2] <= hour_inc[8] ? 8'h00 : hour_inc[7:0];
        end
      end
      if (rtc_reg[0][7] || wr_en[0] || presc == PRESC_MAX) presc <= '0;
      else                                                 presc <= presc + PW'(1);
    end
  end

endmodule

// File: tb/tb_ds1302_rtc_responder.sv
// Directed bench for ds1302_rtc_responder. Two instances share CE/SCLK and
// the bench data: a slow one (no ticks during the run) for register access,
// and a fast one (4-cycle second) for the roll-over sequence.
module tb_ds1302_rtc_responder;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst, ce, sck, tb_oe, tb_bit;
  wire  io_s, io_f;
  assign io_s = tb_oe ? tb_bit : 1'bz;
  assign io_f = tb_oe ? tb_bit : 1'bz;

  logic [63:0] bcd_s, bcd_f;
  logic        tick_s, tick_f, xd_s, xd_f;
  logic [7:0]  xcmd_s, xcmd_f;

  ds1302_rtc_responder #(.TICK_CYCLES(60000)) dut_slow (
    .sclk(clk), .rst(rst), .ds1302_ce(ce), .ds1302_sclk(sck), .ds1302_io(io_s),
    .bcd_time(bcd_s), .tick_pulse(tick_s), .xfer_done(xd_s), .xfer_cmd(xcmd_s)
  );

  ds1302_rtc_responder #(.TICK_CYCLES(4)) dut_fast (
    .sclk(clk), .rst(rst), .ds1302_ce(ce), .ds1302_sclk(sck), .ds1302_io(io_f),
    .bcd_time(bcd_f), .tick_pulse(tick_f), .xfer_done(xd_f), .xfer_cmd(xcmd_f)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int xd_cnt_s = 0;
  int tick_cnt_s = 0;

  // pulse counters for the slow instance
  always @(posedge clk) begin
    if (xd_s === 1'b1)   xd_cnt_s++;
    if (tick_s === 1'b1) tick_cnt_s++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_xfer();
    @(negedge clk);
    sck = 1'b0; ce = 1'b1; tb_oe = 1'b1; tb_bit = 1'b0;
    cyc(5);
  endtask

  task automatic end_xfer();
    @(negedge clk);
    sck = 1'b0;
    cyc(5);
    ce = 1'b0; tb_oe = 1'b0;
    cyc(6);
  endtask

  task automatic send_byte(input logic [7:0] b, input int tail);
    for (int i = 0; i < 8; i++) begin
      sck = 1'b0; tb_oe = 1'b1; tb_bit = b[i];
      cyc(5);
      sck = 1'b1;
      cyc((i == 7) ? tail : 5);
    end
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      sck = 1'b0; tb_oe = 1'b0;
      cyc(4);
      b[i] = io_s;
      cyc(1);
      sck = 1'b1;
      cyc(5);
    end
  endtask

  // drive 0 ourselves: a released line reads 0, a DUT driving 1 shows through
  task automatic check_released(input string tag);
    tb_oe = 1'b1; tb_bit = 1'b0;
    cyc(1);
    check(tag, {63'd0, io_s}, 64'd0);
    tb_oe = 1'b0;
  endtask

  task automatic wr_single(input logic [7:0] cmd, input logic [7:0] data);
    start_xfer();
    send_byte(cmd, 5);
    send_byte(data, 5);
    end_xfer();
  endtask

  task automatic burst_wr(input logic [63:0] d);
    start_xfer();
    send_byte(8'hBE, 5);
    for (int k = 0; k < 8; k++) send_byte(d[k*8 +: 8], 5);
    end_xfer();
  endtask

  initial begin
    logic [7:0]  rb;
    logic [63:0] exp_t;
    int          base;

    rst = 1'b1; ce = 1'b0; sck = 1'b0; tb_oe = 1'b0; tb_bit = 1'b0;
    cyc(5);
    rst = 1'b0;
    cyc(2);

    // reset state
    check("rst_bcd", bcd_s, 64'h8000010101000080);
    check("rst_tick", {63'd0, tick_s}, 64'd0);
    check("rst_xd", {63'd0, xd_s}, 64'd0);
    check("rst_xcmd", {56'd0, xcmd_s}, 64'd0);
    check_released("rst_io");

    // 1: clear wp, then burst write
    wr_single(8'h8E, 8'h00);
    check("t1_wp_clear", {56'd0, bcd_s[63:56]}, 64'h00);
    base = xd_cnt_s;
    burst_wr(64'h0078060815012900);
    check("t1_bcd", bcd_s, 64'h0078060815012900);
    check("t1_xd_once", 64'(xd_cnt_s - base), 64'd1);
    check("t1_xcmd", {56'd0, xcmd_s}, 64'hBE);

    // 2: burst read
    exp_t = 64'h0078060815012900;
    base  = xd_cnt_s;
    start_xfer();
    send_byte(8'hBF, 5);
    for (int k = 0; k < 8; k++) begin
      read_byte(rb);
      check($sformatf("t2_rd_byte%0d", k), {56'd0, rb}, {56'd0, exp_t[k*8 +: 8]});
      if (k == 6) check("t2_no_early_xd", 64'(xd_cnt_s - base), 64'd0);
    end
    check("t2_xd_once", 64'(xd_cnt_s - base), 64'd1);
    check("t2_xcmd", {56'd0, xcmd_s}, 64'hBF);
    sck = 1'b0;
    cyc(5);
    check_released("t2_io_after64");
    end_xfer();

    // 3: write protect on single write, then unprotected
    wr_single(8'h8E, 8'h80);
    check("t3_wp_set", {56'd0, bcd_s[63:56]}, 64'h80);
    base = xd_cnt_s;
    wr_single(8'h82, 8'h45);
    check("t3_min_blocked", {56'd0, bcd_s[15:8]}, 64'h29);
    check("t3_blocked_xd", 64'(xd_cnt_s - base), 64'd1);
    check("t3_blocked_xcmd", {56'd0, xcmd_s}, 64'h82);
    wr_single(8'h8E, 8'h00);
    wr_single(8'h82, 8'h45);
    check("t3_min_written", {56'd0, bcd_s[15:8]}, 64'h45);

    // 4: roll-over on the fast instance: 23:59:59 -> 00:00:00 four cycles after commit
    exp_t = 64'h0078060815235959;
    start_xfer();
    send_byte(8'hBE, 5);
    for (int k = 0; k < 7; k++) send_byte(exp_t[k*8 +: 8], 5);
    send_byte(exp_t[63:56], 0);
    for (int n = 0; n < 20 && xd_f !== 1'b1; n++) cyc(1);
    check("t4_commit_seen", {63'd0, xd_f}, 64'd1);
    check("t4_commit_bcd", bcd_f, exp_t);
    check("t4_xcmd", {56'd0, xcmd_f}, 64'hBE);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      check($sformatf("t4_hold%0d_bcd", k), bcd_f, exp_t);
      check($sformatf("t4_hold%0d_tick", k), {63'd0, tick_f}, 64'd0);
    end
    cyc(1);
    check("t4_wrap_bcd", bcd_f, 64'h0078060815000000);
    check("t4_wrap_tick", {63'd0, tick_f}, 64'd1);
    cyc(1);
    check("t4_tick_one_cycle", {63'd0, tick_f}, 64'd0);
    end_xfer();
    check("t4_slow_bcd", bcd_s, exp_t);

    // 5: aborted burst write after 40 data bits
    base = xd_cnt_s;
    start_xfer();
    send_byte(8'hBE, 5);
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 5);
    end_xfer();
    check("t5_bcd_unchanged", bcd_s, 64'h0078060815235959);
    check("t5_no_xd", 64'(xd_cnt_s - base), 64'd0);
    check_released("t5_io");

    // 6: command with bit7=0 is ignored, then single seconds read
    base = xd_cnt_s;
    start_xfer();
    send_byte(8'h01, 5);
    for (int i = 0; i < 8; i++) begin
      sck = 1'b0; tb_oe = 1'b1; tb_bit = 1'b0;
      cyc(4);
      check($sformatf("t6_ignore_io%0d", i), {63'd0, io_s}, 64'd0);
      cyc(1);
      sck = 1'b1;
      cyc(5);
    end
    end_xfer();
    check("t6_ignore_no_xd", 64'(xd_cnt_s - base), 64'd0);
    start_xfer();
    send_byte(8'h81, 5);
    read_byte(rb);
    check("t6_read_sec", {56'd0, rb}, 64'h59);
    sck = 1'b0;
    cyc(5);
    check_released("t6_io_after8");
    end_xfer();
    check("t6_read_xd", 64'(xd_cnt_s - base), 64'd1);
    check("t6_read_xcmd", {56'd0, xcmd_s}, 64'h81);

    // 7: burst write under write protect updates only wp
    wr_single(8'h8E, 8'h80);
    base = xd_cnt_s;
    burst_wr(64'h0011111111111111);
    check("t7_wp_burst_bcd", bcd_s, 64'h0078060815235959);
    check("t7_wp_burst_xd", 64'(xd_cnt_s - base), 64'd1);

    check("slow_no_ticks", 64'(tick_cnt_s), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
